univ_shift_reg: RTL and testbench

- Parametrised universal shift register built on positive-edge flip-flops: WIDTH-bit storage with hold, shift-right, shift-left and parallel-load modes.
- Adds asynchronous active-low reset and a clock enable.
- Adds a saturating shift counter that reports how many bits have been shifted since the last load.
- Serves as the general storage/serialiser element for later exercises (serial links, counters, LFSRs).

---
 rtl/usr_pkg.sv | 14 +
 rtl/pe_dff_rn.sv | 19 +
 rtl/univ_shift_reg.sv | 103 ++++++++++
 tb/tb_univ_shift_reg.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode encodings and shift-counter sizing shared by univ_shift_reg
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // CNT must represent 0..WIDTH inclusive
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/pe_dff_rn.sv
// rtl/pe_dff_rn.sv - 1-bit rising-edge flop with async active-low reset to a supplied value and enable
module pe_dff_rn (
   input  logic clk,
   input  logic rst_n,
   input  logic rst_val,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= rst_val;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with saturating shift counter
// Optional USR_ROTATE_EN adds ROT, turning shifts into rotates.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                          CK,
   input  logic                          RN,
   input  logic                          EN,
   input  logic [1:0]                    MODE,
   input  logic                          SIR,
   input  logic                          SIL,
   input  logic [WIDTH-1:0]              D,
`ifdef USR_ROTATE_EN
   input  logic                          ROT,
`endif
   output logic [WIDTH-1:0]              Q,
   output logic                          SOR,
   output logic                          SOL,
   output logic [cnt_width(WIDTH)-1:0]   CNT,
   output logic                          FULL
);

   localparam int            CW      = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   logic [WIDTH-1:0] q_next;
   logic [CW-1:0]    cnt_next;
   logic [CW-1:0]    cnt_sat;
   logic             full_next;
   logic             sir_eff;
   logic             sil_eff;

`ifdef USR_ROTATE_EN
   assign sir_eff = ROT ? Q[0]       : SIR;
   assign sil_eff = ROT ? Q[WIDTH-1] : SIL;
`else
   assign sir_eff = SIR;
   assign sil_eff = SIL;
`endif

   assign cnt_sat = (CNT == CNT_MAX) ? CNT : CNT + CW'(1);

   always_comb begin
      q_next   = Q;
      cnt_next = CNT;
      case (MODE)
         MODE_SHR: begin
            q_next   = {sir_eff, Q[WIDTH-1:1]};
            cnt_next = cnt_sat;
         end
         MODE_SHL: begin
            q_next   = {Q[WIDTH-2:0], sil_eff};
            cnt_next = cnt_sat;
         end
         MODE_LOAD: begin
            q_next   = D;
            cnt_next = '0;
         end
         default: ;
      endcase
   end

   // FULL is registered alongside CNT so both move on the same edge
   assign full_next = (cnt_next == CNT_MAX);

   assign SOR = Q[0];
   assign SOL = Q[WIDTH-1];

   for (genvar i = 0; i < WIDTH; i++) begin : g_q
      pe_dff_rn u_q (
         .clk     (CK),
         .rst_n   (RN),
         .rst_val (RESET_VAL[i]),
         .en      (EN),
         .d       (q_next[i]),
         .q       (Q[i])
      );
   end

   for (genvar i = 0; i < CW; i++) begin : g_cnt
      pe_dff_rn u_cnt (
         .clk     (CK),
         .rst_n   (RN),
         .rst_val (1'b0),
         .en      (EN),
         .d       (cnt_next[i]),
         .q       (CNT[i])
      );
   end

   pe_dff_rn u_full (
      .clk     (CK),
      .rst_n   (RN),
      .rst_val (1'b0),
      .en      (EN),
      .d       (full_next),
      .q       (FULL)
   );

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=A5)
module tb_univ_shift_reg;

   localparam logic [7:0] RV = 8'hA5;

   logic       CK   = 1'b0;
   logic       RN   = 1'b1;
   logic       EN   = 1'b0;
   logic [1:0] MODE = 2'b00;
   logic       SIR  = 1'b0;
   logic       SIL  = 1'b0;
   logic       ROT  = 1'b0;
   logic [7:0] D    = 8'h00;
   logic [7:0] Q;
   logic       SOR;
   logic       SOL;
   logic [3:0] CNT;
   logic       FULL;

   int checks = 0;
   int errors = 0;

   logic [7:0]  m_q;
   logic [3:0]  m_cnt;
   logic        m_full;
   logic [14:0] sb[$];
   logic [14:0] exp_v;

   always #5 CK = ~CK;

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(RV)) dut (
      .CK   (CK),
      .RN   (RN),
      .EN   (EN),
      .MODE (MODE),
      .SIR  (SIR),
      .SIL  (SIL),
      .D    (D),
`ifdef USR_ROTATE_EN
      .ROT  (ROT),
`endif
      .Q    (Q),
      .SOR  (SOR),
      .SOL  (SOL),
      .CNT  (CNT),
      .FULL (FULL)
   );

   task automatic model_reset();
      m_q    = RV;
      m_cnt  = 4'd0;
      m_full = 1'b0;
      sb.delete();
   endtask

   // drive one cycle of inputs and queue the state expected after the next edge
   task automatic apply(input logic en, input logic [1:0] mode, input logic sir,
                        input logic sil, input logic [7:0] d, input logic rot);
      EN = en; MODE = mode; SIR = sir; SIL = sil; D = d; ROT = rot;
      if (en) begin
         case (mode)
            2'b01: begin
               m_q = {(rot ? m_q[0] : sir), m_q[7:1]};
               if (m_cnt != 4'd8) m_cnt = m_cnt + 4'd1;
            end
            2'b10: begin
               m_q = {m_q[6:0], (rot ? m_q[7] : sil)};
               if (m_cnt != 4'd8) m_cnt = m_cnt + 4'd1;
            end
            2'b11: begin
               m_q   = d;
               m_cnt = 4'd0;
            end
            default: ;
         endcase
      end
      m_full = (m_cnt == 4'd8);
      sb.push_back({m_q, m_cnt, m_full, m_q[0], m_q[7]});
   endtask

   task automatic test_reset();
      @(negedge CK); #2;
      RN = 1'b0; #1;
      checks++;
      if ({Q, CNT, FULL, SOR, SOL} !== {RV, 4'd0, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL reset_async: got Q=%h CNT=%0d FULL=%b want Q=%h CNT=0 FULL=0", Q, CNT, FULL, RV);
      end
      EN = 1'b1; MODE = 2'b11; D = 8'hFF;
      repeat (2) @(posedge CK);
      #1;
      checks++;
      if ({Q, CNT, FULL} !== {RV, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_held: got Q=%h CNT=%0d FULL=%b want Q=%h CNT=0 FULL=0", Q, CNT, FULL, RV);
      end
      @(negedge CK);
      RN = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 1'b0);
         @(posedge CK); #1;
         exp_v = sb.pop_front();
         checks++;
         if ({Q, CNT, FULL, SOR, SOL} !== exp_v || Q !== RV) begin
            errors++;
            $display("FAIL reset_release_hold%0d: got %h want %h (Q %h)", i, {Q, CNT, FULL, SOR, SOL}, exp_v, RV);
         end
         @(negedge CK);
      end
   endtask

   task automatic test_shift_right();
      logic [7:0] plan_q [3];
      logic       plan_sor [3];
      plan_q   = '{8'h9E, 8'hCF, 8'hE7};
      plan_sor = '{1'b0, 1'b1, 1'b1};
      @(negedge CK);
      apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b0);
      @(posedge CK); #1;
      exp_v = sb.pop_front();
      checks++;
      if ({Q, CNT, FULL, SOR, SOL} !== exp_v || Q !== 8'h3C) begin
         errors++;
         $display("FAIL shr_load: got %h want %h", {Q, CNT, FULL, SOR, SOL}, exp_v);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge CK);
         apply(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
         @(posedge CK); #1;
         exp_v = sb.pop_front();
         checks++;
         if ({Q, CNT, FULL, SOR, SOL} !== exp_v || Q !== plan_q[i] || SOR !== plan_sor[i]
             || CNT !== 4'(i + 1)) begin
            errors++;
            $display("FAIL shr_edge%0d: got Q=%h CNT=%0d SOR=%b want Q=%h CNT=%0d SOR=%b",
                     i + 1, Q, CNT, SOR, plan_q[i], i + 1, plan_sor[i]);
         end
      end
   endtask

   task automatic test_shift_left_saturate();
      @(negedge CK);
      apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0);
      @(posedge CK); #1;
      exp_v = sb.pop_front();
      checks++;
      if ({Q, CNT, FULL, SOR, SOL} !== exp_v) begin
         errors++;
         $display("FAIL shl_load: got %h want %h", {Q, CNT, FULL, SOR, SOL}, exp_v);
      end
      for (int i = 1; i <= 10; i++) begin
         @(negedge CK);
         apply(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0);
         @(posedge CK); #1;
         exp_v = sb.pop_front();
         checks++;
         if ({Q, CNT, FULL, SOR, SOL} !== exp_v) begin
            errors++;
            $display("FAIL shl_edge%0d: got %h want %h", i, {Q, CNT, FULL, SOR, SOL}, exp_v);
         end
         if (i == 1) begin
            checks++;
            if (Q !== 8'h02 || SOL !== 1'b0) begin
               errors++;
               $display("FAIL shl_first: got Q=%h SOL=%b want Q=02 SOL=0", Q, SOL);
            end
         end
         if (i == 8 || i == 10) begin
            checks++;
            if (CNT !== 4'd8 || FULL !== 1'b1 || (i == 10 && Q !== 8'h00)) begin
               errors++;
               $display("FAIL shl_sat%0d: got CNT=%0d FULL=%b Q=%h want CNT=8 FULL=1", i, CNT, FULL, Q);
            end
         end
      end
   endtask

   task automatic test_enable_hold();
      @(negedge CK);
      apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h68, 1'b0);
      @(posedge CK); #1; void'(sb.pop_front());
      @(negedge CK);
      apply(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
      @(posedge CK); #1; void'(sb.pop_front());
      @(negedge CK);
      apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
      @(posedge CK); #1;
      exp_v = sb.pop_front();
      checks++;
      if ({Q, CNT, FULL, SOR, SOL} !== exp_v || Q !== 8'h5A || CNT !== 4'd2) begin
         errors++;
         $display("FAIL en_setup: got Q=%h CNT=%0d want Q=5A CNT=2", Q, CNT);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge CK);
         apply(1'b0, 2'b01, 1'b1, 1'b1, 8'hFF, 1'b0);
         #2; D = 8'h11; SIR = 1'b0;
         @(posedge CK); #1;
         exp_v = sb.pop_front();
         checks++;
         if ({Q, CNT, FULL, SOR, SOL} !== exp_v || Q !== 8'h5A || CNT !== 4'd2) begin
            errors++;
            $display("FAIL en_hold%0d: got Q=%h CNT=%0d want Q=5A CNT=2", i, Q, CNT);
         end
         #2; D = 8'hEE; SIR = 1'b1;
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge CK);
      apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b0);
      @(posedge CK); #1; void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin
         @(negedge CK);
         apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
         @(posedge CK); #1;
         exp_v = sb.pop_front();
         checks++;
         if ({Q, CNT, FULL, SOR, SOL} !== exp_v) begin
            errors++;
            $display("FAIL mid_shift%0d: got %h want %h", i, {Q, CNT, FULL, SOR, SOL}, exp_v);
         end
      end
      #2;
      RN = 1'b0; #1;
      checks++;
      if ({Q, CNT, FULL} !== {RV, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: got Q=%h CNT=%0d FULL=%b want Q=%h CNT=0 FULL=0", Q, CNT, FULL, RV);
      end
      @(negedge CK);
      RN = 1'b1;
      model_reset();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         @(negedge CK);
         apply(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
         @(posedge CK); #1;
         exp_v = sb.pop_front();
         checks++;
         if ({Q, CNT, FULL, SOR, SOL} !== exp_v) begin
            errors++;
            $display("FAIL b2b%0d: got %h want %h", i, {Q, CNT, FULL, SOR, SOL}, exp_v);
         end
      end
   endtask

`ifdef USR_ROTATE_EN
   task automatic test_rotate();
      logic [7:0] plan_q [3];
      plan_q = '{8'hC0, 8'h60, 8'h03};
      for (int i = 0; i < 3; i++) begin
         if (i != 1) begin
            @(negedge CK);
            apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h81, 1'b1);
            @(posedge CK); #1; void'(sb.pop_front());
         end
         @(negedge CK);
         apply(1'b1, (i == 2) ? 2'b10 : 2'b01, 1'(i), 1'(~i), 8'h00, 1'b1);
         #2; SIR = ~SIR; SIL = ~SIL;
         @(posedge CK); #1;
         exp_v = sb.pop_front();
         checks++;
         if ({Q, CNT, FULL, SOR, SOL} !== exp_v || Q !== plan_q[i]) begin
            errors++;
            $display("FAIL rot%0d: got Q=%h want Q=%h", i, Q, plan_q[i]);
         end
      end
      ROT = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_shift_right();
      test_shift_left_saturate();
      test_enable_hold();
      test_reset_mid_op();
      test_back_to_back();
`ifdef USR_ROTATE_EN
      test_rotate();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
